// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/ack channel between the PC sequencer (master)
// and the instruction memory (slave).
interface pc_sequencer_if #(
  parameter int WORDSIZE         = 64,
  parameter int INSTRUCTION_SIZE = 32
);
  logic                        imem_req;
  logic [WORDSIZE-1:0]         imem_addr;
  logic                        imem_ack;
  logic [INSTRUCTION_SIZE-1:0] imem_data;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_data);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_data);
endinterface

// File: rtl/pc_sequencer.sv
// Fetch/execute PC sequencer: IDLE -> FETCH -> EXEC loop with retire counter.
// Optional PC bounds check with a sticky FAULT state under `PC_BOUNDS_CHECK_EN.
module pc_sequencer #(
  parameter int                  WORDSIZE         = 64,
  parameter int                  INSTRUCTION_SIZE = 32,
  parameter logic [WORDSIZE-1:0] RESET_PC         = '0,
  parameter logic [WORDSIZE-1:0] PC_LIMIT         = WORDSIZE'(64'h0000_0000_0000_0FFF)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        halt,
  pc_sequencer_if.master              imem,
  output logic [INSTRUCTION_SIZE-1:0] instr,
  output logic                        instr_valid,
  input  logic                        exec_done,
  input  logic [WORDSIZE-1:0]         pc_inc,
  output logic [WORDSIZE-1:0]         pc,
  output logic                        busy,
  output logic [31:0]                 retired,
  output logic                        fault
);

`ifdef PC_BOUNDS_CHECK_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FAULT} state_e;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_e;
`endif

  state_e                      state_q, state_d;
  logic [WORDSIZE-1:0]         pc_q, pc_d;
  logic [INSTRUCTION_SIZE-1:0] instr_q, instr_d;
  logic [31:0]                 retired_q, retired_d;
  logic [WORDSIZE-1:0]         pc_nxt;

  // Two's-complement add gives the signed wrap for negative branch offsets.
  assign pc_nxt = pc_q + pc_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: if (imem.imem_ack) begin
        instr_d = imem.imem_data;
        state_d = S_EXEC;
      end
      S_EXEC:  if (exec_done) begin
        pc_d      = pc_nxt;
        retired_d = retired_q + 32'd1;
        state_d   = halt ? S_IDLE : S_FETCH;
`ifdef PC_BOUNDS_CHECK_EN
        // Out-of-range target wins over halt; only reset leaves FAULT.
        if (pc_nxt > PC_LIMIT) state_d = S_FAULT;
`endif
      end
`ifdef PC_BOUNDS_CHECK_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  assign imem.imem_req  = (state_q == S_FETCH);
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = (state_q == S_EXEC);
  assign pc             = pc_q;
  assign busy           = (state_q != S_IDLE);
  assign retired        = retired_q;

`ifdef PC_BOUNDS_CHECK_EN
  assign fault = (state_q == S_FAULT);
`else
  logic unused_limit;
  assign unused_limit = ^PC_LIMIT;
  assign fault        = 1'b0;
`endif

endmodule
